// File: rtl/seq_divider_2n_by_n.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.
// Optional DIV_FAST_ZERO_EN: a zero dividend with a nonzero divisor finishes without the CALC pass.
module seq_divider_2n_by_n #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the unconsumed dividend bits at the top and the quotient bits
  // collected so far at the bottom; after WIDTH shifts it is the quotient.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic             dvs_zero, hi_ovf, fast_zero;

  assign dvs_zero = (divisor == '0);
  assign hi_ovf   = (dividend[2*WIDTH-1:WIDTH] >= divisor);
`ifdef DIV_FAST_ZERO_EN
  assign fast_zero = (dividend == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign trial    = {rem_q, quo_q[WIDTH-1]};
  assign trial_ge = (trial >= {1'b0, dvs_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (dvs_zero || hi_ovf || fast_zero) ? DONE : CALC;
      CALC: if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      dvs_d = divisor;
      cnt_d = '0;
      dbz_d = 1'b0;
      ovf_d = 1'b0;
      if (dvs_zero) begin
        dbz_d = 1'b1;
        quo_d = '1;
        rem_d = dividend[WIDTH-1:0];
      end else if (hi_ovf) begin
        ovf_d = 1'b1;
        quo_d = '1;
        rem_d = '0;
      end else if (fast_zero) begin
        quo_d = '0;
        rem_d = '0;
      end else begin
        rem_d = dividend[2*WIDTH-1:WIDTH];
        quo_d = dividend[WIDTH-1:0];
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      // trial < 2*divisor, so the difference always fits in WIDTH bits
      rem_d = trial_ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], trial_ge};
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider_2n_by_n.sv
// Bench for seq_divider_2n_by_n: directed vector table, handshake/reset sequences, random ops vs arithmetic model.
module tb_seq_divider_2n_by_n;
  localparam int W = 32;
`ifdef DIV_FAST_ZERO_EN
  localparam int LAT_ZERO = 0;
`else
  localparam int LAT_ZERO = W;
`endif
  // latency = edges after the accept edge until out_valid is seen; 0 means valid in the very next cycle
  localparam int LAT_FLAG = 0;

  logic           clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor, quotient, remainder;
  logic           div_by_zero, overflow;

  int checks = 0;
  int errors = 0;

  seq_divider_2n_by_n #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dbz;
    logic           ovf;
    int             lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input int hold,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output logic ovf, output int lat);
    int n;
    logic stable;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    dividend = dd; divisor = dv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    q = quotient; r = remainder; dbz = div_by_zero; ovf = overflow;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      dividend = {$urandom, $urandom};
      divisor  = $urandom_range(1, 1000);
      @(posedge clk); #1;
      if (quotient !== q || remainder !== r || div_by_zero !== dbz || overflow !== ovf ||
          in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) chk("held_stable", 64'(stable), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_handoff", {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  vec_t tv[7];
  logic [W-1:0] q, r;
  logic dbz, ovf;
  int lat;

  initial begin
    tv[0] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, W};
    tv[1] = '{64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, W};
    tv[2] = '{64'h12345678_9ABCDEF0, 32'd0, 32'hFFFFFFFF, 32'h9ABCDEF0, 1'b1, 1'b0, LAT_FLAG};
    tv[3] = '{64'h00000005_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, LAT_FLAG};
    tv[4] = '{64'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, LAT_ZERO};
    tv[5] = '{64'h00000004_FFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 1'b0, 1'b0, W};
    tv[6] = '{64'd1, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, W};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready_valid", {62'd0, in_ready, out_valid}, 64'b10);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_flags", {62'd0, div_by_zero, overflow}, 64'd0);

    foreach (tv[i]) begin
      run_op(tv[i].dd, tv[i].dv, 0, q, r, dbz, ovf, lat);
      chk($sformatf("vec%0d_quotient", i), 64'(q), 64'(tv[i].q));
      chk($sformatf("vec%0d_remainder", i), 64'(r), 64'(tv[i].r));
      chk($sformatf("vec%0d_flags", i), {62'd0, dbz, ovf}, {62'd0, tv[i].dbz, tv[i].ovf});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tv[i].lat));
    end

    // back-pressure: result held 10 cycles while in_valid toggles new operands
    run_op(64'd100, 32'd7, 10, q, r, dbz, ovf, lat);
    chk("bp_quotient", 64'(q), 64'd14);
    chk("bp_remainder", 64'(r), 64'd2);
    repeat (W + 4) @(posedge clk);
    #1 chk("bp_no_ghost_op", {62'd0, in_ready, out_valid}, 64'b10);

    // reset 10 cycles into CALC abandons the operation
    dividend = 64'd100; divisor = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("mid_calc_busy", {62'd0, in_ready, out_valid}, 64'b00);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_ready_valid", {62'd0, in_ready, out_valid}, 64'b10);
    chk("mid_rst_outputs", {quotient, remainder}, 64'd0);
    run_op(64'd200, 32'd9, 0, q, r, dbz, ovf, lat);
    chk("after_rst_quotient", 64'(q), 64'd22);
    chk("after_rst_remainder", 64'(r), 64'd2);
    chk("after_rst_latency", 64'(lat), 64'(W));

    // random operations against plain 64-bit arithmetic
    for (int k = 0; k < 40; k++) begin
      logic [2*W-1:0] dd, eq, er;
      logic [W-1:0] dv, hi;
      logic edbz, eovf;
      int elat;
      case ($urandom_range(0, 9))
        0:       dv = '0;
        1:       dv = W'($urandom_range(1, 15));
        default: dv = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0 || dv == '0) dd = {$urandom, $urandom};
      else begin
        hi = $urandom % dv;
        dd = {hi, 32'($urandom)};
      end
      edbz = (dv == '0);
      eovf = !edbz && ((dd >> W) >= 64'(dv));
      if (edbz) begin eq = 64'hFFFFFFFF; er = {32'd0, dd[W-1:0]}; elat = LAT_FLAG; end
      else if (eovf) begin eq = 64'hFFFFFFFF; er = 0; elat = LAT_FLAG; end
      else begin eq = dd / 64'(dv); er = dd % 64'(dv); elat = (dd == 0) ? LAT_ZERO : W; end
      run_op(dd, dv, $urandom_range(0, 2), q, r, dbz, ovf, lat);
      chk($sformatf("rnd%0d_q_r", k), {q, r}, {eq[W-1:0], er[W-1:0]});
      chk($sformatf("rnd%0d_flags", k), {62'd0, dbz, ovf}, {62'd0, edbz, eovf});
      chk($sformatf("rnd%0d_latency", k), 64'(lat), 64'(elat));
      if (!edbz && !eovf)
        chk($sformatf("rnd%0d_identity", k), 64'(q) * 64'(dv) + 64'(r), dd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider_2n_by_n.md
Name: seq_divider_2n_by_n

Overview:
- Iterative restoring divider: 2N-bit dividend / N-bit divisor, yielding an N-bit quotient and an N-bit remainder.
- Inverse operation of the team's combinational 32x32->64 Wallace multiplier. Feeding its 64-bit product and one operand returns the other operand with remainder 0.
- Used in the matrix datapath for normalisation/scaling. Valid/ready handshake on both sides; one result per operation, no overlap.

Parameters:
- WIDTH, 32, divisor/quotient/remainder width. Dividend is 2*WIDTH. Counter width is $clog2(WIDTH).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept operands
- dividend  input  2*WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient does not fit in WIDTH bits

Behaviour:
- One clock (clk). Reset rst is synchronous, active-high; all state changes on rising clk.
- Reset: state=IDLE, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration counter=0. in_ready=1 in the first cycle after reset.
- in_ready = (state==IDLE), decoded from the state register.
- out_valid = (state==DONE), decoded from the state register.
- States: IDLE, CALC, DONE.
- IDLE, on in_valid (transfer edge E0):
  - divisor==0: go to DONE. div_by_zero=1, overflow=0, quotient=all ones, remainder=dividend[WIDTH-1:0].
  - else if dividend[2W-1:W] >= divisor: go to DONE. overflow=1, div_by_zero=0, quotient=all ones, remainder=0.
  - else: go to CALC. Partial remainder R = dividend[2W-1:W]; low shift register = dividend[W-1:0]; count=0; both flags cleared.
- CALC, each cycle:
  - T = {R, next dividend bit, MSB first} (W+1 bits).
  - If T >= divisor: R = T - divisor, quotient bit = 1. Else R = T[W-1:0], quotient bit = 0.
  - Quotient bits shift in at the LSB. count increments.
  - After the iteration with count==WIDTH-1, go to DONE; quotient/remainder registers then hold the final values.
- Latency:
  - Normal op: out_valid rises exactly WIDTH cycles after E0 (32 for default).
  - Zero-divisor / overflow: 1 cycle after E0.
- DONE: quotient, remainder and flags held stable. Exit to IDLE on out_valid && out_ready.
  - in_ready stays 0 in DONE; a new operand cannot be taken in the same cycle as the result handoff. Minimum issue interval is WIDTH+2 cycles.
- in_valid while not IDLE: ignored. Operands are sampled only at E0, so later input changes have no effect.
- Invariant for non-flagged results: quotient*divisor + remainder == dividend, and remainder < divisor.
- rst in any state, including mid-CALC: abandon the operation and return to reset values next edge. No partial result is emitted.

Optional Feature:
- Macro: DIV_FAST_ZERO_EN.
- Defined: in IDLE, a dividend of 0 with divisor!=0 goes directly to DONE. quotient=0, remainder=0, flags 0; out_valid 1 cycle after E0.
- Undefined: a zero dividend takes the normal CALC path, WIDTH cycles, same result values.

Test Plan:
- dividend=64'd100, divisor=32'd7 -> quotient=14, remainder=2, flags 0; out_valid exactly 32 cycles after accept edge.
- dividend=64'hFFFFFFFE_00000001, divisor=32'hFFFFFFFF -> quotient=32'hFFFFFFFF, remainder=0. This reverses the multiplier's max product.
- divisor=0, dividend=64'h1234_5678_9ABC_DEF0 -> div_by_zero=1, quotient=32'hFFFFFFFF, remainder=32'h9ABCDEF0; out_valid 1 cycle after accept.
- dividend=64'h00000005_00000000, divisor=5 -> overflow=1, quotient=32'hFFFFFFFF, remainder=0, 1-cycle latency.
- Result 100/7 with out_ready held low 10 cycles, and in_valid toggled with new operands meanwhile -> outputs stable; in_ready=0 throughout; IDLE only after out_ready=1; toggled operands never processed.
- rst asserted 10 cycles into CALC -> next cycle out_valid=0, in_ready=1, outputs 0. A following 200/9 then yields 22 r 2 after 32 cycles. A zero dividend takes 1 cycle with DIV_FAST_ZERO_EN and 32 cycles without.
